// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with 2-entry skid buffer, flush, NOP bubble and stall counter
module if_id_skid_reg #(
    parameter int                 INSTR_WIDTH = 32,
    parameter int                 PC_WIDTH    = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int                 CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   validIn,
    output logic                   readyOut,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instructionOut,
    output logic [PC_WIDTH-1:0]    pcOut,
    output logic                   validOut,
    input  logic                   readyIn,
    output logic [1:0]             occupancy,
    output logic [CNT_WIDTH-1:0]   stallCount
);

    // Encoding equals the number of held entries so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
    logic [PC_WIDTH-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    logic accept;
    logic deliver;

    // Handshake outputs depend only on registered state: no readyIn -> readyOut path.
    assign validOut       = (state_q != EMPTY);
    assign readyOut       = (state_q != FULL);
    assign occupancy      = state_q;
    assign instructionOut = main_instr_q;
    assign pcOut          = main_pc_q;
    assign stallCount     = stall_cnt_q;

    assign accept  = validIn && readyOut;
    assign deliver = validOut && readyIn;

    // Next-state and datapath selection for the main and skid registers.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // Squash everything, including any entry offered this cycle.
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_instr_d = instruction;
                        main_pc_d    = pc;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_instr_d = instruction;
                        main_pc_d    = pc;
                    end else if (accept) begin
                        skid_instr_d = instruction;
                        skid_pc_d    = pc;
                        state_d      = FULL;
                    end else if (deliver) begin
                        // Bubble: NOP to ID, pc left as the last delivered value.
                        main_instr_d = NOP_INSTR;
                        state_d      = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_pc_d    = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles where ID holds back a valid entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (validOut && !readyIn && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, main register and stall counter with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Skid contents are only meaningful in FULL, so they need no reset.
    always_ff @(posedge clock) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - scoreboard testbench for if_id_skid_reg
module tb_if_id_skid_reg;

    localparam int IW = 32;
    localparam int PW = 32;
    localparam int CW = 4;
    localparam logic [IW-1:0] NOP = 32'h0000_0000;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [IW-1:0] instruction;
    logic [PW-1:0] pc;
    logic          validIn;
    logic          readyOut;
    logic          flush;
    logic [IW-1:0] instructionOut;
    logic [PW-1:0] pcOut;
    logic          validOut;
    logic          readyIn;
    logic [1:0]    occupancy;
    logic [CW-1:0] stallCount;

    if_id_skid_reg #(
        .INSTR_WIDTH(IW),
        .PC_WIDTH   (PW),
        .NOP_INSTR  (NOP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instruction   (instruction),
        .pc            (pc),
        .validIn       (validIn),
        .readyOut      (readyOut),
        .flush         (flush),
        .instructionOut(instructionOut),
        .pcOut         (pcOut),
        .validOut      (validOut),
        .readyIn       (readyIn),
        .occupancy     (occupancy),
        .stallCount    (stallCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } entry_t;

    // Reference model: FIFO of held entries, stall counter, last pc seen by ID.
    entry_t        held[$];
    entry_t        exp_q[$];
    int            m_stall;
    logic [PW-1:0] m_last_pc;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  run      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        entry_t e;
        bit     dlv, acc;
        @(posedge clock);
        e.instr = instruction;
        e.pc    = pc;
        if (reset) begin
            held.delete();
            exp_q.delete();
            m_stall   = 0;
            m_last_pc = '0;
        end else begin
            dlv = (held.size() > 0) && readyIn;
            acc = validIn && (held.size() < 2);
            if ((held.size() > 0) && !readyIn && (m_stall < SAT)) m_stall++;
            if (flush) begin
                held.delete();
                exp_q.delete();
                m_last_pc = '0;
            end else begin
                if (dlv) begin
                    m_last_pc = held[0].pc;
                    void'(held.pop_front());
                end
                if (acc) begin
                    held.push_back(e);
                    exp_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] i, input logic [PW-1:0] p,
                         input logic r, input logic f, input logic rst);
        validIn     = v;
        instruction = i;
        pc          = p;
        readyIn     = r;
        flush       = f;
        reset       = rst;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, validOut, 0);
        chk({tag, "_ready"}, readyOut, 1);
        chk({tag, "_occ"},   occupancy, 0);
        chk({tag, "_instr"}, instructionOut, NOP);
        chk({tag, "_pc"},    pcOut, 0);
        chk({tag, "_stall"}, stallCount, 0);
    endtask

    // Monitor: compare DUT outputs with the model every cycle, pop scoreboard on each delivery.
    always @(negedge clock) begin
        entry_t e;
        if (run) begin
            chk("occupancy", occupancy, held.size());
            chk("validOut",  validOut,  held.size() > 0);
            chk("readyOut",  readyOut,  held.size() < 2);
            chk("stallCount", stallCount, m_stall);
            if (held.size() == 0) begin
                chk("empty_instr", instructionOut, NOP);
                chk("empty_pc",    pcOut, m_last_pc);
            end
            if (validOut && readyIn) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deliver_unexpected: got %0h with empty scoreboard", instructionOut);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_instr", instructionOut, e.instr);
                    chk("deliver_pc",    pcOut, e.pc);
                end
            end
        end
    end

    initial begin
        m_stall   = 0;
        m_last_pc = '0;
        do_reset();
        run = 1'b1;
        chk_reset_vals("reset");

        // Stream at full throughput.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h2008_0001 + k, 32'h4 + 4 * k, 1'b1, 1'b0, 1'b0);
            step();
            chk("stream_instr", instructionOut, 32'h2008_0001 + k);
            chk("stream_occ", occupancy, 1);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk("stream_stall", stallCount, 0);

        // Backpressure into the skid slot.
        do_reset();
        drive(1'b1, 32'h2008_0001, 32'h4, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h2008_0002, 32'h8, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_occ", occupancy, 2);
        chk("bp_ready", readyOut, 0);
        drive(1'b1, 32'h2008_0003, 32'hc, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("bp_stall", stallCount, 3);
        chk("bp_hold", instructionOut, 32'h2008_0001);
        readyIn = 1'b1;
        step();
        chk("bp_drain2", instructionOut, 32'h2008_0002);
        step();
        chk("bp_drain3", instructionOut, 32'h2008_0003);
        validIn = 1'b0;
        step();
        chk("bp_empty", validOut, 0);

        // Flush while FULL with a concurrent offer.
        do_reset();
        drive(1'b1, 32'h1111_0001, 32'h100, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h1111_0002, 32'h104, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h1111_0003, 32'h108, 1'b0, 1'b1, 1'b0);
        step();
        chk("fl_valid", validOut, 0);
        chk("fl_instr", instructionOut, 0);
        chk("fl_pc", pcOut, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_ready", readyOut, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        // Drain to empty leaves pc of the last delivery.
        do_reset();
        drive(1'b1, 32'h8C08_0004, 32'h40, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk("dr_valid", validOut, 0);
        chk("dr_instr", instructionOut, NOP);
        chk("dr_pc", pcOut, 32'h40);

        // Reset mid-FULL, then reset together with flush.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            drive(1'b1, 32'h2222_0001, 32'h200, 1'b0, 1'b0, 1'b0);
            step();
            drive(1'b1, 32'h2222_0002, 32'h204, 1'b0, 1'b0, 1'b0);
            step();
            validIn = 1'b0;
            repeat (4) step();
            chk("rs_stall5", stallCount, 5);
            chk("rs_full", occupancy, 2);
            drive(1'b1, 32'h2222_0003, 32'h208, 1'b0, t[0], 1'b1);
            step();
            chk_reset_vals(t == 0 ? "rs_mid" : "rs_flush");
            reset = 1'b0;
            validIn = 1'b0;
            flush = 1'b0;
        end

        // Counter saturation.
        do_reset();
        drive(1'b1, 32'h3333_0001, 32'h300, 1'b0, 1'b0, 1'b0);
        step();
        validIn = 1'b0;
        repeat (20) step();
        chk("sat_15", stallCount, 15);
        step();
        chk("sat_hold", stallCount, 15);

        // Randomised traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 300) == 0);
            step();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (4) step();
        chk("final_empty", occupancy, 0);

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
